// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI configuration and request/response types used by the bit accumulator sequencer
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/user_bitacc_seq_pkg.sv
// rtl/user_bitacc_seq_pkg.sv - register map, bit indices and FSM states of the bit accumulator sequencer
package user_bitacc_seq_pkg;

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegSrc     = 3'd1;
  localparam logic [2:0] RegLen     = 3'd2;
  localparam logic [2:0] RegAccBase = 3'd3;
  localparam logic [2:0] RegStatus  = 3'd4;
  localparam logic [2:0] RegResult  = 3'd5;

  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlClearBit  = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;
  localparam int unsigned StatusErrBit  = 2;

  // Accumulator window: clear, add-popcount, read-count
  localparam logic [31:0] AccClrOffset = 32'h0;
  localparam logic [31:0] AccAddOffset = 32'h4;
  localparam logic [31:0] AccResOffset = 32'h8;

  typedef enum logic [3:0] {
    IDLE,
    CLR_REQ,
    CLR_WAIT,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    RES_REQ,
    RES_WAIT
  } state_e;

  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_bitacc_seq_regs.sv
// rtl/user_bitacc_seq_regs.sv - configuration subordinate: decode, register file and one-cycle response
module user_bitacc_seq_regs
  import user_bitacc_seq_pkg::*;
#(
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    sbr_req_i,
  output obi_rsp_t    sbr_rsp_o,
  input  logic        busy,
  input  logic        done,
  input  logic        err,
  input  logic [15:0] result,
  output logic        start,
  output logic        clear,
  output logic [31:0] src,
  output logic [15:0] len,
  output logic [31:0] acc_base
);

  logic [2:0]  idx;
  logic        access;
  logic        bad;
  logic        wr_ok;
  logic [31:0] status;
  logic [31:0] rd_val;
  logic [31:0] old_val;
  logic [31:0] new_val;
  obi_rsp_t    rsp_q;
  logic        unused_addr;

  assign unused_addr = ^{sbr_req_i.addr[31:5], sbr_req_i.addr[1:0]};

  always_comb begin
    idx    = sbr_req_i.addr[4:2];
    access = sbr_req_i.req;
    bad    = (idx > RegResult) || (sbr_req_i.we && (idx == RegStatus || idx == RegResult));
    wr_ok  = access && sbr_req_i.we && !bad;

    status                = '0;
    status[StatusBusyBit] = busy;
    status[StatusDoneBit] = done;
    status[StatusErrBit]  = err;

    case (idx)
      RegSrc:     rd_val = src;
      RegLen:     rd_val = {16'h0, len};
      RegAccBase: rd_val = acc_base;
      RegStatus:  rd_val = status;
      RegResult:  rd_val = {16'h0, result};
      default:    rd_val = '0;
    endcase

    case (idx)
      RegSrc:     old_val = src;
      RegLen:     old_val = {16'h0, len};
      RegAccBase: old_val = acc_base;
      default:    old_val = '0;
    endcase
    new_val = apply_be(old_val, sbr_req_i.wdata, sbr_req_i.be);

    start = wr_ok && (idx == RegCtrl) && sbr_req_i.be[0] &&
            sbr_req_i.wdata[CtrlStartBit] && !busy;
    clear = sbr_req_i.wdata[CtrlClearBit];

    sbr_rsp_o     = rsp_q;
    sbr_rsp_o.gnt = sbr_req_i.req;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_q    <= '0;
      src      <= '0;
      len      <= '0;
      acc_base <= '0;
    end else begin
      rsp_q.rvalid <= access;
      if (access) begin
        rsp_q.rid   <= sbr_req_i.aid;
        rsp_q.err   <= bad;
        rsp_q.rdata <= (sbr_req_i.we || bad) ? '0 : rd_val;
      end
      // Configuration is frozen while a sequence runs
      if (wr_ok && !busy) begin
        case (idx)
          RegSrc:     src      <= new_val;
          RegLen:     len      <= new_val[15:0];
          RegAccBase: acc_base <= new_val;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: rtl/user_bitacc_seq.sv
// rtl/user_bitacc_seq.sv - sequencer streaming LEN source words into a bit accumulator over an OBI manager
module user_bitacc_seq
  import user_bitacc_seq_pkg::*;
#(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t sbr_req_i,
  output obi_rsp_t sbr_rsp_o,
  output obi_req_t mgr_req_o,
  input  obi_rsp_t mgr_rsp_i,
  output logic     irq_o
);

  localparam int unsigned AddrW = ObiCfg.AddrWidth;

  state_e           state_q, state_d;
  logic             busy_q, done_q, err_q;
  logic [15:0]      cnt_q;
  logic [AddrW-1:0] ptr_q;
  logic [31:0]      data_q;
  logic [15:0]      result_q;
  logic             start, clear;
  logic [31:0]      src, acc_base;
  logic [15:0]      len;
  logic             in_wait;
  logic             unused_rid;

  assign unused_rid = ^mgr_rsp_i.rid;

  user_bitacc_seq_regs #(
    .obi_req_t(obi_req_t),
    .obi_rsp_t(obi_rsp_t)
  ) u_regs (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .sbr_req_i(sbr_req_i),
    .sbr_rsp_o(sbr_rsp_o),
    .busy     (busy_q),
    .done     (done_q),
    .err      (err_q),
    .result   (result_q),
    .start    (start),
    .clear    (clear),
    .src      (src),
    .len      (len),
    .acc_base (acc_base)
  );

  assign in_wait = (state_q == CLR_WAIT) || (state_q == RD_WAIT) ||
                   (state_q == WR_WAIT)  || (state_q == RES_WAIT);

  always_comb begin
    state_d       = state_q;
    mgr_req_o     = '0;
    mgr_req_o.be  = 4'hF;
    mgr_req_o.aid = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (clear)             state_d = CLR_REQ;
          else if (len != 16'd0) state_d = RD_REQ;
          else                   state_d = RES_REQ;
        end
      end
      CLR_REQ: begin
        mgr_req_o.req  = 1'b1;
        mgr_req_o.we   = 1'b1;
        mgr_req_o.addr = acc_base + AccClrOffset;
        if (mgr_rsp_i.gnt) state_d = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (mgr_rsp_i.rvalid) begin
          if (mgr_rsp_i.err)       state_d = IDLE;
          else if (cnt_q != 16'd0) state_d = RD_REQ;
          else                     state_d = RES_REQ;
        end
      end
      RD_REQ: begin
        mgr_req_o.req  = 1'b1;
        mgr_req_o.addr = 32'(ptr_q);
        if (mgr_rsp_i.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mgr_rsp_i.rvalid) state_d = mgr_rsp_i.err ? IDLE : WR_REQ;
      end
      WR_REQ: begin
        mgr_req_o.req   = 1'b1;
        mgr_req_o.we    = 1'b1;
        mgr_req_o.addr  = acc_base + AccAddOffset;
        mgr_req_o.wdata = data_q;
        if (mgr_rsp_i.gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        // cnt_q is decremented on this same edge, so test against 1
        if (mgr_rsp_i.rvalid) begin
          if (mgr_rsp_i.err)       state_d = IDLE;
          else if (cnt_q != 16'd1) state_d = RD_REQ;
          else                     state_d = RES_REQ;
        end
      end
      RES_REQ: begin
        mgr_req_o.req  = 1'b1;
        mgr_req_o.addr = acc_base + AccResOffset;
        if (mgr_rsp_i.gnt) state_d = RES_WAIT;
      end
      RES_WAIT: begin
        if (mgr_rsp_i.rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      irq_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_o   <= 1'b0;
      if (state_q == IDLE && start) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
        err_q  <= 1'b0;
        cnt_q  <= len;
        ptr_q  <= src[AddrW-1:0];
      end
      if (in_wait && mgr_rsp_i.rvalid) begin
        if (mgr_rsp_i.err) begin
          err_q  <= 1'b1;
          busy_q <= 1'b0;
          irq_o  <= 1'b1;
        end else begin
          case (state_q)
            RD_WAIT: data_q <= mgr_rsp_i.rdata;
            WR_WAIT: begin
              cnt_q <= cnt_q - 16'd1;
              ptr_q <= ptr_q + AddrW'(4);
            end
            RES_WAIT: begin
              result_q <= mgr_rsp_i.rdata[15:0];
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              irq_o    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_user_bitacc_seq.sv
// tb/tb_user_bitacc_seq.sv - scoreboard bench for user_bitacc_seq with an OBI memory/accumulator responder
module tb_user_bitacc_seq;
  import obi_pkg::*;

  localparam logic [31:0] A_CTRL = 32'h00, A_SRC = 32'h04, A_LEN = 32'h08;
  localparam logic [31:0] A_ACC = 32'h0C, A_STATUS = 32'h10, A_RESULT = 32'h14;
  localparam logic [31:0] SRC = 32'h1000_0000, BASE = 32'h2000_0000;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mgr_exp_t;
  typedef struct { logic [31:0] rdata; logic err; string name; } sbr_exp_t;

  logic clk, rst_n, irq;
  obi_req_t sbr_req, mgr_req;
  obi_rsp_t sbr_rsp, mgr_rsp;

  mgr_exp_t exp_mgr[$];
  sbr_exp_t exp_sbr[$];
  logic [31:0] mem [logic [31:0]];
  int n_vec, n_err;
  int gnt_dly, rsp_dly, rd_err_at, src_reads, irq_cnt, grant_cnt;
  logic [31:0] acc_val;

  user_bitacc_seq #(
    .ObiCfg(ObiDefaultConfig), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .sbr_req_i(sbr_req), .sbr_rsp_o(sbr_rsp),
    .mgr_req_o(mgr_req), .mgr_rsp_i(mgr_rsp), .irq_o(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source memory plus bit accumulator: +0 clears, +4 adds popcount, +8 reads count
  initial begin
    int wait_cnt, pend_cnt;
    bit pend, pend_err;
    logic [31:0] pend_data;
    wait_cnt = 0; pend = 0; pend_cnt = 0; pend_err = 0; pend_data = '0;
    mgr_rsp = '0;
    forever begin
      @(posedge clk); #1;
      mgr_rsp.gnt = 0; mgr_rsp.rvalid = 0; mgr_rsp.err = 0; mgr_rsp.rdata = '0;
      if (pend) begin
        if (pend_cnt == 0) begin
          mgr_rsp.rvalid = 1; mgr_rsp.rdata = pend_data; mgr_rsp.err = pend_err; pend = 0;
        end else pend_cnt--;
      end
      if (mgr_req.req) begin
        if (wait_cnt >= gnt_dly) begin
          mgr_rsp.gnt = 1; wait_cnt = 0; pend = 1; pend_cnt = rsp_dly - 1;
          pend_err = 0; pend_data = '0;
          if (mgr_req.we) begin
            if (mgr_req.addr == BASE) acc_val = mgr_req.wdata;
            else if (mgr_req.addr == BASE + 4) acc_val += 32'($countones(mgr_req.wdata));
          end else if (mgr_req.addr == BASE + 8) pend_data = acc_val;
          else begin
            src_reads++;
            pend_data = mem.exists(mgr_req.addr) ? mem[mgr_req.addr] : '0;
            if (src_reads == rd_err_at) pend_err = 1;
          end
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction or response
  initial begin
    bit hold_pend, outst, irq_prev;
    logic [31:0] hold_addr;
    mgr_exp_t m;
    sbr_exp_t s;
    hold_pend = 0; outst = 0; irq_prev = 0; hold_addr = '0;
    forever begin
      @(negedge clk);
      if (hold_pend && rst_n) begin
        check("req_hold", 32'(mgr_req.req), 32'd1);
        check("addr_hold", mgr_req.addr, hold_addr);
      end
      hold_pend = rst_n && mgr_req.req && !mgr_rsp.gnt;
      hold_addr = mgr_req.addr;
      if (mgr_rsp.rvalid) outst = 0;
      if (mgr_req.req && mgr_rsp.gnt) begin
        grant_cnt++;
        check("one_outstanding", 32'(outst), 32'd0);
        outst = 1;
        if (exp_mgr.size() == 0) check("unexpected_mgr_req", mgr_req.addr, 32'hDEAD_BEEF);
        else begin
          m = exp_mgr.pop_front();
          check("mgr_we", 32'(mgr_req.we), 32'(m.we));
          check("mgr_addr", mgr_req.addr, m.addr);
          if (m.we) check("mgr_wdata", mgr_req.wdata, m.wdata);
        end
      end
      if (sbr_rsp.rvalid) begin
        if (exp_sbr.size() == 0) check("unexpected_sbr_rvalid", sbr_rsp.rdata, 32'hDEAD_BEEF);
        else begin
          s = exp_sbr.pop_front();
          check({s.name, "_rdata"}, sbr_rsp.rdata, s.rdata);
          check({s.name, "_err"}, 32'(sbr_rsp.err), 32'(s.err));
        end
      end
      if (irq) begin
        irq_cnt++;
        check("irq_width", 32'(irq_prev), 32'd0);
      end
      irq_prev = irq;
    end
  end

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    exp_sbr.push_back('{exp_rdata, exp_err, name});
    sbr_req.req = 1; sbr_req.we = we; sbr_req.addr = addr;
    sbr_req.wdata = wdata; sbr_req.be = 4'hF; sbr_req.aid = '0;
    @(posedge clk); #1;
    sbr_req.req = 0; sbr_req.we = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic exp_err,
                    input string name);
    xfer(1'b1, addr, data, 32'h0, exp_err, name);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err,
                    input string name);
    xfer(1'b0, addr, 32'h0, exp, exp_err, name);
  endtask

  task automatic em(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_mgr.push_back('{we, addr, wdata});
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int bound, input string name);
    int n0;
    bit seen;
    n0 = irq_cnt; seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (irq_cnt != n0) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic push_full_run(input bit with_clear, input int n);
    logic [31:0] words [3];
    words[0] = 32'hFFFF_FFFF; words[1] = 32'h0000_000F; words[2] = 32'h8000_0001;
    if (with_clear) em(1, BASE, 32'h0);
    for (int i = 0; i < n; i++) begin
      em(0, SRC + 32'(4 * i), 32'h0);
      em(1, BASE + 4, words[i]);
    end
    em(0, BASE + 8, 32'h0);
  endtask

  initial begin
    int irq0, g0;
    bit seen;
    n_vec = 0; n_err = 0; irq_cnt = 0; grant_cnt = 0;
    gnt_dly = 0; rsp_dly = 1; rd_err_at = 0; src_reads = 0; acc_val = 32'h55;
    rst_n = 0; sbr_req = '0;
    mem[SRC] = 32'hFFFF_FFFF; mem[SRC + 4] = 32'h0000_000F; mem[SRC + 8] = 32'h8000_0001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mgr_req", 32'(mgr_req.req), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
    rst_n = 1;
    drain(1);
    rd(A_STATUS, 32'h0, 0, "rst_status");
    rd(A_RESULT, 32'h0, 0, "rst_result");
    rd(A_SRC, 32'h0, 0, "rst_src");

    // Full run with clear: 32 + 4 + 2 = 38
    irq0 = irq_cnt;
    wr(A_SRC, SRC, 0, "wr_src"); wr(A_LEN, 32'd3, 0, "wr_len"); wr(A_ACC, BASE, 0, "wr_acc");
    push_full_run(1, 3);
    wr(A_CTRL, 32'h3, 0, "t1_ctrl");
    wait_irq(300, "t1_done");
    drain(3);
    rd(A_STATUS, 32'h2, 0, "t1_status"); rd(A_RESULT, 32'd38, 0, "t1_result");
    rd(A_LEN, 32'd3, 0, "t1_len"); rd(A_CTRL, 32'h0, 0, "t1_ctrl_rd");
    drain(2);
    check("t1_irq_count", 32'(irq_cnt - irq0), 32'd1);
    check("t1_mgr_drained", 32'(exp_mgr.size()), 32'd0);

    // LEN=0, no clear: result is the accumulator's low half
    acc_val = 32'h0001_2345;
    wr(A_LEN, 32'd0, 0, "t2_len");
    em(0, BASE + 8, 32'h0);
    wr(A_CTRL, 32'h1, 0, "t2_ctrl");
    wait_irq(100, "t2_done");
    drain(2);
    rd(A_RESULT, 32'h2345, 0, "t2_result"); rd(A_STATUS, 32'h2, 0, "t2_status");

    // Slow manager: gnt after 3 cycles, rvalid 5 cycles later
    gnt_dly = 3; rsp_dly = 5;
    wr(A_LEN, 32'd3, 0, "t3_len");
    push_full_run(1, 3);
    wr(A_CTRL, 32'h3, 0, "t3_ctrl");
    wait_irq(1000, "t3_done");
    drain(2);
    rd(A_RESULT, 32'd38, 0, "t3_result"); rd(A_STATUS, 32'h2, 0, "t3_status");

    // Error on the second source read
    gnt_dly = 0; rsp_dly = 1; src_reads = 0; rd_err_at = 2; irq0 = irq_cnt;
    em(1, BASE, 32'h0); em(0, SRC, 32'h0); em(1, BASE + 4, 32'hFFFF_FFFF); em(0, SRC + 4, 32'h0);
    wr(A_CTRL, 32'h3, 0, "t4_ctrl");
    wait_irq(200, "t4_done");
    drain(12);
    rd(A_STATUS, 32'h4, 0, "t4_status"); rd(A_RESULT, 32'd38, 0, "t4_result");
    drain(2);
    check("t4_irq_count", 32'(irq_cnt - irq0), 32'd1);
    check("t4_no_more_req", 32'(exp_mgr.size()), 32'd0);
    rd_err_at = 0;

    // Writes while busy are ignored; accumulator holds 32 from the aborted run, +32 +4
    gnt_dly = 2; rsp_dly = 3; irq0 = irq_cnt;
    wr(A_LEN, 32'd2, 0, "t5_len");
    push_full_run(0, 2);
    wr(A_CTRL, 32'h1, 0, "t5_ctrl");
    wr(A_LEN, 32'd5, 0, "t5_len_busy");
    wr(A_CTRL, 32'h3, 0, "t5_start_busy");
    wr(A_ACC, 32'h3000_0000, 0, "t5_acc_busy");
    wr(A_STATUS, 32'h0, 1, "t5_wr_status");
    rd(A_STATUS, 32'h1, 0, "t5_busy");
    wait_irq(1000, "t5_done");
    drain(2);
    rd(A_RESULT, 32'd68, 0, "t5_result"); rd(A_LEN, 32'd2, 0, "t5_len_rd");
    rd(A_ACC, BASE, 0, "t5_acc_rd"); rd(A_STATUS, 32'h2, 0, "t5_status");
    rd(32'h18, 32'h0, 1, "t5_bad_addr"); wr(A_RESULT, 32'h1, 1, "t5_wr_result");
    drain(2);
    check("t5_irq_count", 32'(irq_cnt - irq0), 32'd1);

    // Reset while waiting on the first source read, then a stray rvalid
    gnt_dly = 0; rsp_dly = 8; irq0 = irq_cnt; g0 = grant_cnt; seen = 0;
    wr(A_LEN, 32'd3, 0, "t6_len");
    em(0, SRC, 32'h0);
    wr(A_CTRL, 32'h1, 0, "t6_ctrl");
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (grant_cnt != g0) seen = 1;
    end
    check("t6_first_read", 32'(seen), 32'd1);
    drain(1);
    rst_n = 0;
    drain(2);
    check("t6_rst_mgr_req", 32'(mgr_req.req), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
    rst_n = 1;
    drain(15);
    rd(A_STATUS, 32'h0, 0, "t6_status"); rd(A_RESULT, 32'h0, 0, "t6_result");
    rd(A_SRC, 32'h0, 0, "t6_src"); rd(A_LEN, 32'h0, 0, "t6_len_rd");
    rd(A_ACC, 32'h0, 0, "t6_acc");
    drain(3);
    check("t6_no_irq", 32'(irq_cnt - irq0), 32'd0);
    check("end_mgr_queue", 32'(exp_mgr.size()), 32'd0);
    check("end_sbr_queue", 32'(exp_sbr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
